// File: rtl/div_pkg.sv
// Shared types and constants for the sequential non-restoring divider.
package div_pkg;

   localparam int DIV_WIDTH = 32;

   // One quotient bit is produced per iteration.
   localparam int ITER_COUNT = DIV_WIDTH;

   // Quotient reported when the divisor is zero.
   localparam logic [DIV_WIDTH-1:0] DBZ_QUOTIENT = {DIV_WIDTH{1'b1}};

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      FIX  = 2'd2,
      DONE = 2'd3
   } div_state_t;

endpackage

// File: rtl/div_step.sv
// One non-restoring division iteration on magnitudes.
// The partial remainder is WIDTH+1 bits so that it can go negative and so
// that a divisor magnitude of 2**(WIDTH-1) stays representable.
module div_step #(
   parameter int WIDTH = 32
) (
   input  logic [WIDTH:0]   a,
   input  logic [WIDTH-1:0] qr,
   input  logic [WIDTH:0]   m,
   output logic [WIDTH:0]   a_next,
   output logic [WIDTH-1:0] qr_next
);

   logic [WIDTH:0] a_shift;

   // Shift {A,Qr} left, then subtract or add the divisor depending on the sign of A.
   always_comb begin
      a_shift = {a[WIDTH-1:0], qr[WIDTH-1]};
      // The shifted value may wrap modulo 2**(WIDTH+1); the sum lands back in
      // [-|M|, |M|) so the wrapped arithmetic still yields the exact result.
      a_next  = a[WIDTH] ? (a_shift + m) : (a_shift - m);
      qr_next = {qr[WIDTH-2:0], ~a_next[WIDTH]};
   end

endmodule

// File: rtl/booth_divider.sv
// Sequential WIDTH-bit integer divider, one quotient bit per clock.
// Result is packed as {remainder, quotient} so it shares the multiplier's
// HI/LO writeback path. Quotient truncates toward zero and the remainder
// takes the sign of the dividend.
module booth_divider
   import div_pkg::*;
#(
   parameter int WIDTH = DIV_WIDTH
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 DIV,
   input  logic                 is_signed,
   input  logic [WIDTH-1:0]     Q,
   input  logic [WIDTH-1:0]     M,
   output logic [2*WIDTH-1:0]   P,
   output logic                 busy,
   output logic                 done,
   output logic                 div_by_zero
);

   localparam int CNT_W = $clog2(WIDTH);
   localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(WIDTH - 1);

   div_state_t       state;
   logic [CNT_W-1:0] cnt;
   logic [WIDTH:0]   a_reg;
   logic [WIDTH-1:0] qr_reg;
   logic [WIDTH:0]   m_abs_reg;
   logic             q_neg;
   logic             m_neg;

   logic             q_neg_in;
   logic             m_neg_in;
   logic [WIDTH-1:0] q_abs;
   logic [WIDTH-1:0] m_abs;
   logic [WIDTH:0]   a_next;
   logic [WIDTH-1:0] qr_next;
   logic [WIDTH-1:0] rem_lo;
   logic [WIDTH-1:0] rem_out;
   logic [WIDTH-1:0] quo_out;

   // Operand magnitudes and sign flags at acceptance; the most negative value
   // maps onto itself, which reads correctly as an unsigned magnitude.
   always_comb begin
      q_neg_in = is_signed & Q[WIDTH-1];
      m_neg_in = is_signed & M[WIDTH-1];
      q_abs    = q_neg_in ? -Q : Q;
      m_abs    = m_neg_in ? -M : M;
   end

   div_step #(.WIDTH(WIDTH)) u_step (
      .a       (a_reg),
      .qr      (qr_reg),
      .m       (m_abs_reg),
      .a_next  (a_next),
      .qr_next (qr_next)
   );

   // Final remainder restore and sign correction applied in FIX.
   always_comb begin
      rem_lo  = a_reg[WIDTH] ? (a_reg[WIDTH-1:0] + m_abs_reg[WIDTH-1:0])
                             : a_reg[WIDTH-1:0];
      rem_out = q_neg ? -rem_lo : rem_lo;
      quo_out = (q_neg ^ m_neg) ? -qr_reg : qr_reg;
   end

   // Control FSM, iteration datapath and registered outputs.
   // NOTE: every state register here uses <= so all updates see pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= IDLE;
         cnt         <= '0;
         a_reg       <= '0;
         qr_reg      <= '0;
         m_abs_reg   <= '0;
         q_neg       <= 1'b0;
         m_neg       <= 1'b0;
         P           <= '0;
         busy        <= 1'b0;
         done        <= 1'b0;
         div_by_zero <= 1'b0;
      end else begin
         case (state)
            IDLE, DONE: begin
               done <= 1'b0;
               if (DIV) begin
                  if (M == '0) begin
                     // Zero divisor skips iteration entirely.
                     P           <= {Q, DBZ_QUOTIENT[WIDTH-1:0]};
                     div_by_zero <= 1'b1;
                     done        <= 1'b1;
                     state       <= DONE;
                  end else begin
                     a_reg       <= '0;
                     qr_reg      <= q_abs;
                     m_abs_reg   <= {1'b0, m_abs};
                     q_neg       <= q_neg_in;
                     m_neg       <= m_neg_in;
                     cnt         <= '0;
                     busy        <= 1'b1;
                     div_by_zero <= 1'b0;
                     state       <= CALC;
                  end
               end else begin
                  state <= IDLE;
               end
            end
            CALC: begin
               a_reg  <= a_next;
               qr_reg <= qr_next;
               cnt    <= cnt + 1'b1;
               if (cnt == LAST_STEP) begin
                  state <= FIX;
               end
            end
            FIX: begin
               P     <= {rem_out, quo_out};
               done  <= 1'b1;
               busy  <= 1'b0;
               state <= DONE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_booth_divider.sv
// Self-checking bench for booth_divider: directed corner cases, handshake and
// reset behaviour, plus randomized operations against a plain-arithmetic model.
module tb_booth_divider;

   logic        clk;
   logic        rst_n;
   logic        DIV;
   logic        is_signed;
   logic [31:0] Q;
   logic [31:0] M;
   logic [63:0] P;
   logic        busy;
   logic        done;
   logic        div_by_zero;

   int n_cmp;
   int n_bad;

   booth_divider #(.WIDTH(32)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .DIV         (DIV),
      .is_signed   (is_signed),
      .Q           (Q),
      .M           (M),
      .P           (P),
      .busy        (busy),
      .done        (done),
      .div_by_zero (div_by_zero)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // Reference: quotient truncated toward zero, remainder signed like the dividend.
   function automatic logic [63:0] ref_div(input logic [31:0] q, input logic [31:0] m,
                                           input logic s);
      longint a, b, qq, rr;
      if (m == 32'd0) return {q, 32'hFFFF_FFFF};
      if (s) begin
         a = longint'(signed'(q));
         b = longint'(signed'(m));
      end else begin
         a = longint'({32'd0, q});
         b = longint'({32'd0, m});
      end
      qq = a / b;
      rr = a % b;
      return {rr[31:0], qq[31:0]};
   endfunction

   // Drive a one-cycle start pulse; returns #1 after the accept edge.
   task automatic start_op(input logic [31:0] q, input logic [31:0] m, input logic s);
      @(negedge clk);
      DIV       = 1'b1;
      Q         = q;
      M         = m;
      is_signed = s;
      @(posedge clk);
      #1;
      DIV = 1'b0;
   endtask

   // Count edges until done is seen (bounded), and cycles with busy high.
   task automatic wait_done(output int n, output int busy_cycles);
      n = 0;
      busy_cycles = busy ? 1 : 0;
      while (!done && n < 60) begin
         @(posedge clk);
         #1;
         n++;
         if (busy) busy_cycles++;
      end
   endtask

   task automatic run_op(input string tag, input logic [31:0] q, input logic [31:0] m,
                         input logic s, input logic use_const, input logic [63:0] exp_const);
      int n, nb;
      logic [63:0] exp;
      exp = use_const ? exp_const : ref_div(q, m, s);
      start_op(q, m, s);
      wait_done(n, nb);
      check({tag, "_lat"}, 64'(n), (m == 0) ? 64'd0 : 64'd33);
      check({tag, "_busy"}, 64'(nb), (m == 0) ? 64'd0 : 64'd33);
      check({tag, "_P"}, P, exp);
      check({tag, "_dbz"}, 64'(div_by_zero), 64'(m == 0));
      @(posedge clk);
      #1;
      check({tag, "_pulse"}, 64'(done), 64'd0);
      check({tag, "_hold"}, P, exp);
   endtask

   initial begin
      int n, nb, dcount;
      logic [31:0] rq, rm;
      logic rs;
      n_cmp = 0;
      n_bad = 0;
      DIV = 1'b0;
      is_signed = 1'b0;
      Q = '0;
      M = '0;
      rst_n = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check("rst_P", P, 64'd0);
      check("rst_busy", 64'(busy), 64'd0);
      check("rst_done", 64'(done), 64'd0);
      check("rst_dbz", 64'(div_by_zero), 64'd0);
      @(negedge clk);
      rst_n = 1'b1;

      run_op("s100_7",  32'd100,          32'd7,          1'b1, 1'b1, 64'h0000_0002_0000_000E);
      run_op("sm100_7", -32'sd100,        32'd7,          1'b1, 1'b1, 64'hFFFF_FFFE_FFFF_FFF2);
      run_op("s100_m7", 32'd100,          -32'sd7,        1'b1, 1'b1, 64'h0000_0002_FFFF_FFF2);
      run_op("u_ff_2",  32'hFFFF_FFFF,    32'd2,          1'b0, 1'b1, 64'h0000_0001_7FFF_FFFF);
      run_op("s_m1_2",  32'hFFFF_FFFF,    32'd2,          1'b1, 1'b1, 64'hFFFF_FFFF_0000_0000);
      run_op("dbz",     32'd5,            32'd0,          1'b0, 1'b1, 64'h0000_0005_FFFF_FFFF);
      run_op("ovf",     32'h8000_0000,    32'hFFFF_FFFF,  1'b1, 1'b1, 64'h0000_0000_8000_0000);
      run_op("u_big",   32'hFFFF_FFFF,    32'hFFFF_FFFE,  1'b0, 1'b1, 64'h0000_0001_0000_0001);

      for (int i = 0; i < 40; i++) begin
         rq = $urandom;
         rs = 1'($urandom_range(0, 1));
         case ($urandom_range(0, 7))
            0:       rm = 32'd0;
            1, 2:    rm = $urandom_range(1, 20);
            3:       rm = -$urandom_range(1, 20);
            default: rm = $urandom;
         endcase
         run_op($sformatf("rnd%0d", i), rq, rm, rs, 1'b0, 64'd0);
      end

      // Start pulse while busy must be ignored.
      start_op(32'd100, 32'd7, 1'b1);
      repeat (9) @(posedge clk);
      @(negedge clk);
      DIV = 1'b1;
      Q = 32'd9;
      M = 32'd3;
      @(posedge clk);
      #1;
      DIV = 1'b0;
      wait_done(n, nb);
      check("ign_lat", 64'(n), 64'd23);
      check("ign_P", P, 64'h0000_0002_0000_000E);

      // Back-to-back start issued during the DONE cycle.
      check("b2b_in_done", 64'(done), 64'd1);
      DIV = 1'b1;
      Q = 32'd9;
      M = 32'd3;
      is_signed = 1'b1;
      @(posedge clk);
      #1;
      DIV = 1'b0;
      wait_done(n, nb);
      check("b2b_lat", 64'(n), 64'd33);
      check("b2b_P", P, 64'h0000_0000_0000_0003);
      @(posedge clk);
      #1;

      // Reset in the middle of an operation aborts it without a done pulse.
      start_op(32'd100, 32'd7, 1'b1);
      repeat (19) @(posedge clk);
      @(posedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      check("abort_P", P, 64'd0);
      check("abort_busy", 64'(busy), 64'd0);
      check("abort_done", 64'(done), 64'd0);
      @(negedge clk);
      rst_n = 1'b1;
      dcount = 0;
      repeat (50) begin
         @(posedge clk);
         #1;
         if (done || busy) dcount++;
      end
      check("abort_quiet", 64'(dcount), 64'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/booth_divider.md
Name: booth_divider

Overview:
- Sequential 32-bit integer divider: the inverse operation of the datapath's combinational radix-4 Booth multiplier.
- Computes quotient and remainder of Q / M by non-restoring division, one quotient bit per clock.
- Result is packed as {remainder, quotient} in a 64-bit bus, mirroring the multiplier's 64-bit P output, so the ALU HI/LO writeback is shared.
- Start/busy/done handshake; sits beside the multiplier in the ALU.

Parameters:
- WIDTH, 32, operand width in bits; result bus is 2*WIDTH.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- DIV  in  1  start pulse; sampled on the rising edge of clk.
- is_signed  in  1  1 = signed (two's complement), 0 = unsigned; sampled with DIV.
- Q  in  WIDTH  dividend; sampled with DIV.
- M  in  WIDTH  divisor; sampled with DIV.
- P  out  2*WIDTH  {remainder[63:32], quotient[31:0]}; held until the next accepted start.
- busy  out  1  high while a division is in progress.
- done  out  1  one-cycle pulse when P is valid.
- div_by_zero  out  1  valid with done; held with P.

Behaviour:
- Reset (async, rst_n=0):
  - State is IDLE.
  - P=0, busy=0, done=0, div_by_zero=0.
  - Iteration counter is 0.
  - A reset during CALC or FIX aborts the operation and produces no done pulse.
- States: IDLE, CALC, FIX, DONE.
- Start acceptance:
  - DIV is accepted only in IDLE or DONE.
  - DIV in CALC or FIX is ignored, with no effect on the operands or P.
- Accept at edge k, M != 0:
  - Latch |Q| and |M| (absolute values only when is_signed=1) and the sign flags.
  - Clear the partial remainder (WIDTH+1 bits) and load the quotient register with |Q|.
  - Next state CALC, counter=0, busy=1.
- CALC:
  - Each edge k+1..k+32 performs one non-restoring step:
    - shift {A,Qr} left by 1;
    - if A >= 0 then A = A - |M|, else A = A + |M|;
    - Qr[0] = ~A[sign].
  - Counter increments each step; after the 32nd step (edge k+32) the next state is FIX.
- FIX (edge k+33):
  - If A < 0, restore A = A + |M|.
  - Signed mode: negate the quotient if sign(Q) != sign(M); negate the remainder if Q < 0.
  - Register P, set done=1, clear busy; next state DONE.
- DONE:
  - done=1 for exactly this one cycle.
  - Returns to IDLE unless DIV is accepted, which gives back-to-back operations.
- Latency: done is high during the cycle after edge k+33.
- Divide-by-zero:
  - If M == 0 at acceptance, bypass CALC and go directly to DONE at edge k.
  - P = {Q, 32'hFFFF_FFFF}, div_by_zero=1, busy never asserts.
- Signed overflow, 0x8000_0000 / 0xFFFF_FFFF with is_signed=1: quotient=0x8000_0000, remainder=0, div_by_zero=0. This falls out naturally from 33-bit arithmetic on the magnitudes.
- Width rules:
  - Magnitudes are held in WIDTH+1 bits so that |0x8000_0000| is representable.
  - Final results are truncated to WIDTH.
  - Quotient truncates toward zero; the remainder takes the sign of the dividend.
- div_by_zero is cleared on the next accepted start.

Decomposition:
- Package div_pkg:
  - state enum {IDLE, CALC, FIX, DONE};
  - WIDTH default;
  - ITER_COUNT = WIDTH;
  - DBZ_QUOTIENT = all-ones constant.
- One combinational sub-module, div_step:
  - inputs A, Qr and |M|;
  - outputs the next A and Qr for a single non-restoring iteration.
  - It is instantiated once and reused each cycle.
- The FSM, counter, sign handling and output registers live in booth_divider.

Test Plan:
1. Signed 100 / 7, is_signed=1: DIV at edge 0 → P=64'h0000_0002_0000_000E; done pulses exactly one cycle, in the cycle after edge 33; busy is high for cycles 1–33.
2. Signed -100 / 7: P=64'hFFFF_FFFE_FFFF_FFF2; repeat as 100 / -7 → P=64'h0000_0002_FFFF_FFF2.
3. Unsigned 0xFFFF_FFFF / 2, is_signed=0: P=64'h0000_0001_7FFF_FFFF. The same operands with is_signed=1 (-1/2) give P=64'hFFFF_FFFF_0000_0000.
4. Divide-by-zero, 5 / 0: done in the cycle after the accept edge, div_by_zero=1, P=64'h0000_0005_FFFF_FFFF, busy stays 0.
5. Overflow, 0x8000_0000 / 0xFFFF_FFFF signed: P=64'h0000_0000_8000_0000, div_by_zero=0.
6. Handshake and reset:
   - A second DIV (9/3) pulsed at edge 10 of a busy 100/7 operation is ignored, and the result stays 14 rem 2.
   - DIV asserted during the DONE cycle starts 9/3 immediately → P=64'h0000_0000_0000_0003, 33 cycles later.
   - rst_n low at edge 20 of an operation clears P, busy and done asynchronously; no done pulse follows.
